// File: rtl/raifes_hasti_rr_arbiter_pkg.sv
// Shared types and constants for the HASTI round-robin arbiter.
//   - Bus field widths and HTRANS/HRESP encodings
//   - Default peripheral window (base/mask)
//   - Request buffer record, memory-port FSM state and grant owner types
package raifes_hasti_rr_arbiter_pkg;

    localparam int unsigned HASTI_ADDR_WIDTH  = 32;
    localparam int unsigned HASTI_BUS_WIDTH   = 32;
    localparam int unsigned HASTI_SIZE_WIDTH  = 3;
    localparam int unsigned HASTI_PROT_WIDTH  = 4;
    localparam int unsigned HASTI_TRANS_WIDTH = 2;
    localparam int unsigned HASTI_RESP_WIDTH  = 1;

    localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_IDLE   = 2'b00;
    localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_BUSY   = 2'b01;
    localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_NONSEQ = 2'b10;
    localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_SEQ    = 2'b11;

    localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_OKAY  = 1'b0;
    localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_ERROR = 1'b1;

    localparam logic [HASTI_ADDR_WIDTH-1:0] PER_BASE_DEFAULT = 32'h4000_0000;
    localparam logic [HASTI_ADDR_WIDTH-1:0] PER_MASK_DEFAULT = 32'hF000_0000;

    typedef enum logic {TgtMem, TgtPer} target_e;

    typedef enum logic [1:0] {MIdle, MDataI, MDataD} mem_state_e;

    typedef enum logic {GntImem, GntDmem} master_e;

    // Address-phase controls captured from one master.
    typedef struct packed {
        logic [HASTI_ADDR_WIDTH-1:0] addr;
        logic                        write;
        logic [HASTI_SIZE_WIDTH-1:0] size;
        logic [HASTI_PROT_WIDTH-1:0] prot;
        logic                        lock;
        target_e                     target;
    } req_t;

    function automatic logic in_window(input logic [HASTI_ADDR_WIDTH-1:0] addr,
                                       input logic [HASTI_ADDR_WIDTH-1:0] base,
                                       input logic [HASTI_ADDR_WIDTH-1:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/raifes_hasti_req_buf.sv
// Per-master request buffer.
// Captures a master's address phase whenever the master sees hready=1 with an active
// transfer (NONSEQ/SEQ), holds it until the arbiter issues it and the data phase completes,
// and produces the master-side hready/hrdata/hresp.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   haddr..hmastlock      master address-phase inputs
//   per_hit               captured address targets the peripheral port
//   issue                 arbiter drives this buffer's address phase this cycle
//   owner                 this master owns the data phase currently in progress
//   slv_*                 response of the slave owning the data phase
//   req / valid / pending buffered request, buffer occupied, occupied and not yet issued
//   hready/hrdata/hresp   master handshake/response
module raifes_hasti_req_buf
    import raifes_hasti_rr_arbiter_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic [HASTI_ADDR_WIDTH-1:0]  haddr,
    input  logic                         hwrite,
    input  logic [HASTI_SIZE_WIDTH-1:0]  hsize,
    input  logic [HASTI_PROT_WIDTH-1:0]  hprot,
    input  logic [HASTI_TRANS_WIDTH-1:0] htrans,
    input  logic                         hmastlock,
    input  logic                         per_hit,
    input  logic                         issue,
    input  logic                         owner,
    input  logic                         slv_hready,
    input  logic [HASTI_BUS_WIDTH-1:0]   slv_hrdata,
    input  logic [HASTI_RESP_WIDTH-1:0]  slv_hresp,
    output req_t                         req,
    output logic                         valid,
    output logic                         pending,
    output logic                         hready,
    output logic [HASTI_BUS_WIDTH-1:0]   hrdata,
    output logic [HASTI_RESP_WIDTH-1:0]  hresp
);

    logic valid_q;
    logic issued_q;
    req_t req_q;
    logic done;
    logic capture;
    logic unused_htrans;

    // Only htrans[1] distinguishes NONSEQ/SEQ from IDLE/BUSY.
    assign unused_htrans = htrans[0];

    assign done    = owner & slv_hready;
    assign hready  = ~valid_q | done;
    assign capture = hready & htrans[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            issued_q <= 1'b0;
            req_q    <= '0;
        end else if (capture) begin
            // A completing master may present its next address in the same cycle.
            valid_q  <= 1'b1;
            issued_q <= 1'b0;
            req_q    <= '{addr:   haddr,
                          write:  hwrite,
                          size:   hsize,
                          prot:   hprot,
                          lock:   hmastlock,
                          target: per_hit ? TgtPer : TgtMem};
        end else if (done) begin
            valid_q  <= 1'b0;
            issued_q <= 1'b0;
        end else if (issue) begin
            issued_q <= 1'b1;
        end
    end

    assign req     = req_q;
    assign valid   = valid_q;
    assign pending = valid_q & ~issued_q;
    assign hrdata  = owner ? slv_hrdata : '0;
    assign hresp   = owner ? slv_hresp : HASTI_RESP_OKAY;

endmodule

// File: rtl/raifes_hasti_rr_arbiter.sv
// Round-robin HASTI arbiter: imem and dmem share the memory slave port; dmem accesses in
// the peripheral window go to a dedicated peripheral port instead.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   imem_* / dmem_*         master address/data inputs, hrdata/hready/hresp outputs
//   mem_*                   shared memory slave: address phase + hwdata out, response in
//   per_*                   peripheral slave (dmem only): address phase + hwdata out,
//                           response in
module raifes_hasti_rr_arbiter
    import raifes_hasti_rr_arbiter_pkg::*;
#(
    parameter logic [HASTI_ADDR_WIDTH-1:0] PER_BASE = PER_BASE_DEFAULT,
    parameter logic [HASTI_ADDR_WIDTH-1:0] PER_MASK = PER_MASK_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic [HASTI_ADDR_WIDTH-1:0]  imem_haddr,
    input  logic                         imem_hwrite,
    input  logic [HASTI_SIZE_WIDTH-1:0]  imem_hsize,
    input  logic [HASTI_PROT_WIDTH-1:0]  imem_hprot,
    input  logic [HASTI_TRANS_WIDTH-1:0] imem_htrans,
    input  logic [HASTI_BUS_WIDTH-1:0]   imem_hwdata,
    output logic [HASTI_BUS_WIDTH-1:0]   imem_hrdata,
    output logic                         imem_hready,
    output logic [HASTI_RESP_WIDTH-1:0]  imem_hresp,

    input  logic [HASTI_ADDR_WIDTH-1:0]  dmem_haddr,
    input  logic                         dmem_hwrite,
    input  logic [HASTI_SIZE_WIDTH-1:0]  dmem_hsize,
    input  logic [HASTI_PROT_WIDTH-1:0]  dmem_hprot,
    input  logic [HASTI_TRANS_WIDTH-1:0] dmem_htrans,
    input  logic                         dmem_hmastlock,
    input  logic [HASTI_BUS_WIDTH-1:0]   dmem_hwdata,
    output logic [HASTI_BUS_WIDTH-1:0]   dmem_hrdata,
    output logic                         dmem_hready,
    output logic [HASTI_RESP_WIDTH-1:0]  dmem_hresp,

    output logic [HASTI_ADDR_WIDTH-1:0]  mem_haddr,
    output logic                         mem_hwrite,
    output logic [HASTI_SIZE_WIDTH-1:0]  mem_hsize,
    output logic [HASTI_PROT_WIDTH-1:0]  mem_hprot,
    output logic [HASTI_TRANS_WIDTH-1:0] mem_htrans,
    output logic                         mem_hmastlock,
    output logic [HASTI_BUS_WIDTH-1:0]   mem_hwdata,
    input  logic [HASTI_BUS_WIDTH-1:0]   mem_hrdata,
    input  logic                         mem_hready,
    input  logic [HASTI_RESP_WIDTH-1:0]  mem_hresp,

    output logic [HASTI_ADDR_WIDTH-1:0]  per_haddr,
    output logic                         per_hwrite,
    output logic [HASTI_SIZE_WIDTH-1:0]  per_hsize,
    output logic [HASTI_TRANS_WIDTH-1:0] per_htrans,
    output logic [HASTI_BUS_WIDTH-1:0]   per_hwdata,
    input  logic [HASTI_BUS_WIDTH-1:0]   per_hrdata,
    input  logic                         per_hready,
    input  logic [HASTI_RESP_WIDTH-1:0]  per_hresp
);

    req_t       imem_req;
    req_t       dmem_req;
    logic       unused_imem_valid;
    logic       dmem_valid;
    logic       imem_pending;
    logic       dmem_pending;
    logic       imem_mem_pending;
    logic       dmem_mem_pending;
    logic       imem_issue;
    logic       dmem_issue;
    logic       per_issue;
    logic       can_issue;

    logic       imem_owner;
    logic       dmem_owner;
    logic       dmem_slv_hready;
    logic [HASTI_BUS_WIDTH-1:0]  dmem_slv_hrdata;
    logic [HASTI_RESP_WIDTH-1:0] dmem_slv_hresp;

    mem_state_e state_q, state_d;
    master_e    last_grant_q, last_grant_d;
    logic       lock_q, lock_d;       // last dmem issue on mem was locked
    logic       per_data_q, per_data_d;

    raifes_hasti_req_buf u_imem_buf (
        .clk        (clk),
        .reset      (reset),
        .haddr      (imem_haddr),
        .hwrite     (imem_hwrite),
        .hsize      (imem_hsize),
        .hprot      (imem_hprot),
        .htrans     (imem_htrans),
        .hmastlock  (1'b0),
        .per_hit    (1'b0),
        .issue      (imem_issue),
        .owner      (imem_owner),
        .slv_hready (mem_hready),
        .slv_hrdata (mem_hrdata),
        .slv_hresp  (mem_hresp),
        .req        (imem_req),
        .valid      (unused_imem_valid),
        .pending    (imem_pending),
        .hready     (imem_hready),
        .hrdata     (imem_hrdata),
        .hresp      (imem_hresp)
    );

    raifes_hasti_req_buf u_dmem_buf (
        .clk        (clk),
        .reset      (reset),
        .haddr      (dmem_haddr),
        .hwrite     (dmem_hwrite),
        .hsize      (dmem_hsize),
        .hprot      (dmem_hprot),
        .htrans     (dmem_htrans),
        .hmastlock  (dmem_hmastlock),
        .per_hit    (in_window(dmem_haddr, PER_BASE, PER_MASK)),
        .issue      (dmem_issue | per_issue),
        .owner      (dmem_owner),
        .slv_hready (dmem_slv_hready),
        .slv_hrdata (dmem_slv_hrdata),
        .slv_hresp  (dmem_slv_hresp),
        .req        (dmem_req),
        .valid      (dmem_valid),
        .pending    (dmem_pending),
        .hready     (dmem_hready),
        .hrdata     (dmem_hrdata),
        .hresp      (dmem_hresp)
    );

    assign imem_mem_pending = imem_pending & (imem_req.target == TgtMem);
    assign dmem_mem_pending = dmem_pending & (dmem_req.target == TgtMem);
    assign per_issue        = dmem_pending & (dmem_req.target == TgtPer);

    assign imem_owner = (state_q == MDataI);
    assign dmem_owner = (state_q == MDataD) | per_data_q;

    // The dmem buffer is in a data phase on at most one of the two slaves.
    assign dmem_slv_hready = per_data_q ? per_hready : mem_hready;
    assign dmem_slv_hrdata = per_data_q ? per_hrdata : mem_hrdata;
    assign dmem_slv_hresp  = per_data_q ? per_hresp  : mem_hresp;

    // Grant and memory-port FSM next state.
    always_comb begin
        imem_issue   = 1'b0;
        dmem_issue   = 1'b0;
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lock_d       = lock_q;
        can_issue    = (state_q == MIdle) | mem_hready;

        if (can_issue) begin
            if (lock_q && dmem_valid) begin
                // Locked sequence in progress: imem waits until dmem lets go.
                dmem_issue = dmem_mem_pending;
            end else if (imem_mem_pending && dmem_mem_pending) begin
                if (last_grant_q == GntDmem) begin
                    imem_issue = 1'b1;
                end else begin
                    dmem_issue = 1'b1;
                end
            end else begin
                imem_issue = imem_mem_pending;
                dmem_issue = dmem_mem_pending;
            end
        end

        if (imem_issue) begin
            state_d      = MDataI;
            last_grant_d = GntImem;
        end else if (dmem_issue) begin
            state_d      = MDataD;
            last_grant_d = GntDmem;
            lock_d       = dmem_req.lock;
        end else if (state_q != MIdle && mem_hready) begin
            state_d = MIdle;
        end
    end

    always_comb begin
        per_data_d = per_data_q;
        if (per_issue) begin
            per_data_d = 1'b1;
        end else if (per_data_q && per_hready) begin
            per_data_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= MIdle;
            last_grant_q <= GntDmem;
            lock_q       <= 1'b0;
            per_data_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
            per_data_q   <= per_data_d;
        end
    end

    // Memory address phase straight from the granted buffer.
    always_comb begin
        mem_haddr     = '0;
        mem_hwrite    = 1'b0;
        mem_hsize     = '0;
        mem_hprot     = '0;
        mem_htrans    = HASTI_TRANS_IDLE;
        mem_hmastlock = 1'b0;
        if (imem_issue) begin
            mem_haddr     = imem_req.addr;
            mem_hwrite    = imem_req.write;
            mem_hsize     = imem_req.size;
            mem_hprot     = imem_req.prot;
            mem_htrans    = HASTI_TRANS_NONSEQ;
            mem_hmastlock = imem_req.lock;
        end else if (dmem_issue) begin
            mem_haddr     = dmem_req.addr;
            mem_hwrite    = dmem_req.write;
            mem_hsize     = dmem_req.size;
            mem_hprot     = dmem_req.prot;
            mem_htrans    = HASTI_TRANS_NONSEQ;
            mem_hmastlock = dmem_req.lock;
        end
    end

    always_comb begin
        mem_hwdata = '0;
        unique case (state_q)
            MDataI:  mem_hwdata = imem_hwdata;
            MDataD:  mem_hwdata = dmem_hwdata;
            default: mem_hwdata = '0;
        endcase
    end

    always_comb begin
        per_haddr  = '0;
        per_hwrite = 1'b0;
        per_hsize  = '0;
        per_htrans = HASTI_TRANS_IDLE;
        if (per_issue) begin
            per_haddr  = dmem_req.addr;
            per_hwrite = dmem_req.write;
            per_hsize  = dmem_req.size;
            per_htrans = HASTI_TRANS_NONSEQ;
        end
    end

    assign per_hwdata = per_data_q ? dmem_hwdata : '0;

endmodule

// File: tb/tb_raifes_hasti_rr_arbiter.sv
module tb_raifes_hasti_rr_arbiter;
    import raifes_hasti_rr_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_haddr, dmem_haddr;
    logic        imem_hwrite, dmem_hwrite;
    logic [2:0]  imem_hsize, dmem_hsize;
    logic [3:0]  imem_hprot, dmem_hprot;
    logic [1:0]  imem_htrans, dmem_htrans;
    logic        dmem_hmastlock;
    logic [31:0] imem_hwdata, dmem_hwdata;
    logic [31:0] imem_hrdata, dmem_hrdata;
    logic        imem_hready, dmem_hready;
    logic        imem_hresp, dmem_hresp;
    logic [31:0] mem_haddr;
    logic        mem_hwrite;
    logic [2:0]  mem_hsize;
    logic [3:0]  mem_hprot;
    logic [1:0]  mem_htrans;
    logic        mem_hmastlock;
    logic [31:0] mem_hwdata, mem_hrdata;
    logic        mem_hready;
    logic        mem_hresp;
    logic [31:0] per_haddr;
    logic        per_hwrite;
    logic [2:0]  per_hsize;
    logic [1:0]  per_htrans;
    logic [31:0] per_hwdata, per_hrdata;
    logic        per_hready;
    logic        per_hresp;

    int total = 0;
    int bad = 0;

    raifes_hasti_rr_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .imem_haddr     (imem_haddr),
        .imem_hwrite    (imem_hwrite),
        .imem_hsize     (imem_hsize),
        .imem_hprot     (imem_hprot),
        .imem_htrans    (imem_htrans),
        .imem_hwdata    (imem_hwdata),
        .imem_hrdata    (imem_hrdata),
        .imem_hready    (imem_hready),
        .imem_hresp     (imem_hresp),
        .dmem_haddr     (dmem_haddr),
        .dmem_hwrite    (dmem_hwrite),
        .dmem_hsize     (dmem_hsize),
        .dmem_hprot     (dmem_hprot),
        .dmem_htrans    (dmem_htrans),
        .dmem_hmastlock (dmem_hmastlock),
        .dmem_hwdata    (dmem_hwdata),
        .dmem_hrdata    (dmem_hrdata),
        .dmem_hready    (dmem_hready),
        .dmem_hresp     (dmem_hresp),
        .mem_haddr      (mem_haddr),
        .mem_hwrite     (mem_hwrite),
        .mem_hsize      (mem_hsize),
        .mem_hprot      (mem_hprot),
        .mem_htrans     (mem_htrans),
        .mem_hmastlock  (mem_hmastlock),
        .mem_hwdata     (mem_hwdata),
        .mem_hrdata     (mem_hrdata),
        .mem_hready     (mem_hready),
        .mem_hresp      (mem_hresp),
        .per_haddr      (per_haddr),
        .per_hwrite     (per_hwrite),
        .per_hsize      (per_hsize),
        .per_htrans     (per_htrans),
        .per_hwdata     (per_hwdata),
        .per_hrdata     (per_hrdata),
        .per_hready     (per_hready),
        .per_hresp      (per_hresp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset          = 1'b1;
        imem_haddr     = '0;
        imem_hwrite    = 1'b0;
        imem_hsize     = 3'd2;
        imem_hprot     = 4'h0;
        imem_htrans    = 2'b00;
        imem_hwdata    = '0;
        dmem_haddr     = '0;
        dmem_hwrite    = 1'b0;
        dmem_hsize     = 3'd2;
        dmem_hprot     = 4'h0;
        dmem_htrans    = 2'b00;
        dmem_hmastlock = 1'b0;
        dmem_hwdata    = '0;
        mem_hrdata     = '0;
        mem_hready     = 1'b1;
        mem_hresp      = 1'b0;
        per_hrdata     = '0;
        per_hready     = 1'b1;
        per_hresp      = 1'b0;

        // Reset state
        tick();
        tick();
        settle();
        chk("rst_imem_hready", {31'b0, imem_hready}, 32'd1);
        chk("rst_dmem_hready", {31'b0, dmem_hready}, 32'd1);
        chk("rst_mem_htrans", {30'b0, mem_htrans}, 32'd0);
        chk("rst_per_htrans", {30'b0, per_htrans}, 32'd0);
        chk("rst_imem_hrdata", imem_hrdata, 32'd0);
        chk("rst_mem_haddr", mem_haddr, 32'd0);
        reset = 1'b0;

        // imem read 0x100, zero-wait slave
        imem_haddr  = 32'h0000_0100;
        imem_htrans = 2'b10;
        tick();
        imem_htrans = 2'b00;
        settle();
        chk("t1_mem_haddr", mem_haddr, 32'h0000_0100);
        chk("t1_mem_htrans", {30'b0, mem_htrans}, 32'd2);
        chk("t1_imem_wait", {31'b0, imem_hready}, 32'd0);
        tick();
        mem_hrdata = 32'hDEAD_BEEF;
        settle();
        chk("t1_imem_hready", {31'b0, imem_hready}, 32'd1);
        chk("t1_imem_hrdata", imem_hrdata, 32'hDEAD_BEEF);
        chk("t1_mem_idle", {30'b0, mem_htrans}, 32'd0);
        tick();
        mem_hrdata = '0;

        // Tie from reset: imem first, then dmem write
        reset = 1'b1;
        tick();
        reset       = 1'b0;
        imem_haddr  = 32'h0000_0200;
        imem_htrans = 2'b10;
        dmem_haddr  = 32'h8000_0000;
        dmem_hwrite = 1'b1;
        dmem_htrans = 2'b10;
        tick();
        imem_htrans = 2'b00;
        dmem_htrans = 2'b00;
        dmem_hwdata = 32'h1234_5678;
        settle();
        chk("t2_first_addr", mem_haddr, 32'h0000_0200);
        chk("t2_first_write", {31'b0, mem_hwrite}, 32'd0);
        chk("t2_dmem_wait0", {31'b0, dmem_hready}, 32'd0);
        tick();
        mem_hrdata = 32'h1111_0200;
        settle();
        chk("t2_second_addr", mem_haddr, 32'h8000_0000);
        chk("t2_second_write", {31'b0, mem_hwrite}, 32'd1);
        chk("t2_imem_done", {31'b0, imem_hready}, 32'd1);
        chk("t2_imem_hrdata", imem_hrdata, 32'h1111_0200);
        chk("t2_dmem_wait1", {31'b0, dmem_hready}, 32'd0);
        chk("t2_dmem_nonowner_rdata", dmem_hrdata, 32'd0);
        tick();
        mem_hrdata = '0;
        settle();
        chk("t2_mem_hwdata", mem_hwdata, 32'h1234_5678);
        chk("t2_dmem_done", {31'b0, dmem_hready}, 32'd1);
        tick();
        dmem_hwrite = 1'b0;
        // imem-only transfer so the following tie must go to dmem
        imem_haddr  = 32'h0000_0300;
        imem_htrans = 2'b10;
        tick();
        imem_htrans = 2'b00;
        settle();
        chk("t2b_imem_addr", mem_haddr, 32'h0000_0300);
        tick();
        imem_haddr  = 32'h0000_0304;
        imem_htrans = 2'b10;
        dmem_haddr  = 32'h8000_0010;
        dmem_htrans = 2'b10;
        settle();
        chk("t2b_imem_done", {31'b0, imem_hready}, 32'd1);
        tick();
        imem_htrans = 2'b00;
        dmem_htrans = 2'b00;
        settle();
        chk("t2b_tie_dmem", mem_haddr, 32'h8000_0010);
        tick();
        settle();
        chk("t2b_then_imem", mem_haddr, 32'h0000_0304);
        chk("t2b_dmem_done", {31'b0, dmem_hready}, 32'd1);
        tick();
        settle();
        chk("t2b_imem_done2", {31'b0, imem_hready}, 32'd1);
        tick();

        // dmem write to peripheral window while imem streams
        imem_haddr  = 32'h0000_1000;
        imem_htrans = 2'b10;
        dmem_haddr  = 32'h4000_0004;
        dmem_hwrite = 1'b1;
        dmem_htrans = 2'b10;
        tick();
        imem_haddr  = 32'h0000_1004;
        dmem_htrans = 2'b00;
        dmem_hwdata = 32'h0000_00A5;
        settle();
        chk("t3_mem_addr0", mem_haddr, 32'h0000_1000);
        chk("t3_per_htrans", {30'b0, per_htrans}, 32'd2);
        chk("t3_per_haddr", per_haddr, 32'h4000_0004);
        chk("t3_per_hwrite", {31'b0, per_hwrite}, 32'd1);
        tick();
        mem_hrdata = 32'hC0DE_1000;
        settle();
        chk("t3_per_hwdata", per_hwdata, 32'h0000_00A5);
        chk("t3_per_idle", {30'b0, per_htrans}, 32'd0);
        chk("t3_dmem_done", {31'b0, dmem_hready}, 32'd1);
        chk("t3_imem_hrdata", imem_hrdata, 32'hC0DE_1000);
        tick();
        mem_hrdata  = '0;
        imem_haddr  = 32'h0000_1008;
        settle();
        chk("t3_mem_addr1", mem_haddr, 32'h0000_1004);
        chk("t3_mem_htrans1", {30'b0, mem_htrans}, 32'd2);
        tick();
        imem_htrans = 2'b00;
        dmem_hwrite = 1'b0;
        settle();
        chk("t3_imem_done1", {31'b0, imem_hready}, 32'd1);
        tick();

        // Slave wait states during imem data phase with dmem pending
        imem_haddr  = 32'h0000_2000;
        imem_htrans = 2'b10;
        tick();
        imem_htrans = 2'b00;
        dmem_haddr  = 32'h8000_0020;
        dmem_htrans = 2'b10;
        settle();
        chk("t4_imem_addr", mem_haddr, 32'h0000_2000);
        tick();
        dmem_htrans = 2'b00;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            mem_hready = 1'b0;
            settle();
            chk("t4_imem_wait", {31'b0, imem_hready}, 32'd0);
            chk("t4_dmem_wait", {31'b0, dmem_hready}, 32'd0);
            chk("t4_no_issue", {30'b0, mem_htrans}, 32'd0);
        end
        tick();
        mem_hready = 1'b1;
        mem_hrdata = 32'h2222_2222;
        settle();
        chk("t4_imem_done", {31'b0, imem_hready}, 32'd1);
        chk("t4_imem_hrdata", imem_hrdata, 32'h2222_2222);
        chk("t4_dmem_issued", mem_haddr, 32'h8000_0020);
        chk("t4_dmem_still_wait", {31'b0, dmem_hready}, 32'd0);
        tick();
        mem_hrdata = 32'h3333_3333;
        settle();
        chk("t4_dmem_done", {31'b0, dmem_hready}, 32'd1);
        chk("t4_dmem_hrdata", dmem_hrdata, 32'h3333_3333);
        tick();
        mem_hrdata = '0;

        // Locked dmem sequence of 3 holds off pending imem
        dmem_haddr     = 32'h8000_0100;
        dmem_htrans    = 2'b10;
        dmem_hmastlock = 1'b1;
        tick();
        imem_haddr     = 32'h0000_3000;
        imem_htrans    = 2'b10;
        dmem_haddr     = 32'h8000_0104;
        settle();
        chk("t5_lk0_addr", mem_haddr, 32'h8000_0100);
        chk("t5_lk0_lock", {31'b0, mem_hmastlock}, 32'd1);
        tick();
        settle();
        chk("t5_imem_blocked0", {30'b0, mem_htrans}, 32'd0);
        chk("t5_lk0_done", {31'b0, dmem_hready}, 32'd1);
        tick();
        dmem_haddr = 32'h8000_0108;
        settle();
        chk("t5_lk1_addr", mem_haddr, 32'h8000_0104);
        chk("t5_lk1_lock", {31'b0, mem_hmastlock}, 32'd1);
        tick();
        settle();
        chk("t5_imem_blocked1", {30'b0, mem_htrans}, 32'd0);
        tick();
        dmem_htrans    = 2'b00;
        dmem_hmastlock = 1'b0;
        settle();
        chk("t5_lk2_addr", mem_haddr, 32'h8000_0108);
        tick();
        settle();
        chk("t5_imem_blocked2", {30'b0, mem_htrans}, 32'd0);
        chk("t5_imem_wait", {31'b0, imem_hready}, 32'd0);
        tick();
        imem_htrans = 2'b00;
        settle();
        chk("t5_imem_addr", mem_haddr, 32'h0000_3000);
        chk("t5_imem_nolock", {31'b0, mem_hmastlock}, 32'd0);
        tick();
        settle();
        chk("t5_imem_done", {31'b0, imem_hready}, 32'd1);
        tick();

        // Reset during dmem data phase with slave stalled
        dmem_haddr  = 32'h8000_0200;
        dmem_htrans = 2'b10;
        tick();
        dmem_htrans = 2'b00;
        settle();
        chk("t6_dmem_addr", mem_haddr, 32'h8000_0200);
        tick();
        mem_hready = 1'b0;
        reset      = 1'b1;
        settle();
        chk("t6_dmem_stalled", {31'b0, dmem_hready}, 32'd0);
        tick();
        reset      = 1'b0;
        mem_hready = 1'b1;
        mem_hrdata = 32'hBAD0_BAD0;
        settle();
        chk("t6_imem_hready", {31'b0, imem_hready}, 32'd1);
        chk("t6_dmem_hready", {31'b0, dmem_hready}, 32'd1);
        chk("t6_mem_idle", {30'b0, mem_htrans}, 32'd0);
        chk("t6_no_stale_rdata", dmem_hrdata, 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
